spram_arbiter: RTL
==================

Name: spram_arbiter

Overview:
- Shares the single byte-addressed SPRAM wrapper (`mem`: 15-bit byte address, 8-bit data, registered pipeline) between two requesters.
  - Port A: CPU fetch/load/store.
  - Port B: host loader / debug.
- Uses round-robin arbitration and a req/ack handshake.
- Sequences the wrapper's fixed multi-cycle access window so requesters never see its internal pipeline.
- Sits between the core/loader and the `mem` instance; is the only driver of its inputs.

Parameters:
- MEM_LAT, 3: clk edges from wrapper inputs becoming stable until mem_data_out is valid.
- ADDR_W, 15: byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_req  in  1  port A request (level, held until a_ack)
- a_write  in  1  port A: 1 = store byte, 0 = load byte
- a_addr  in  ADDR_W  port A byte address
- a_wdata  in  8  port A store data
- a_ack  out  1  port A one-cycle completion pulse
- a_rdata  out  8  port A load data, valid when a_ack=1, held afterwards
- b_req, b_write, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B
- mem_addr  out  ADDR_W  byte address to the wrapper
- mem_write  out  1  write enable to the wrapper
- mem_data_in  out  8  store data to the wrapper
- mem_data_out  in  8  load data from the wrapper

Behaviour:
- All outputs are registered.
- Reset values: mem_addr=0, mem_write=0, mem_data_in=0, a_ack=b_ack=0, a_rdata=b_rdata=0, state=IDLE, cnt=0, last_grant=B (so A wins the first tie).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE; mem_write=0.
  - Only one req: grant that port.
  - Both req: grant the port not equal to last_grant.
  - On grant at edge T:
    - Latch the winner's addr/write/wdata into mem_addr/mem_write/mem_data_in.
    - Set last_grant to the winner, cnt=0, state=ACCESS.
    - Record the winner in an internal `owner` bit.
- ACCESS:
  - mem_addr, mem_write and mem_data_in are held constant; cnt increments each edge.
  - At the edge where cnt==MEM_LAT (edge T+MEM_LAT+1):
    - For a load, capture mem_data_out into the owner's rdata; the other port's rdata is untouched.
    - For a store, rdata is unchanged.
    - Set the owner's ack=1, mem_write=0, state=DONE.
- DONE:
  - Lasts exactly one cycle, during which ack is high; requests are ignored.
  - Next edge: ack=0, state=IDLE.
- Timing:
  - With MEM_LAT=3, ack is high in the cycle following edge T+4.
  - The earliest next grant is edge T+6, i.e. 6 cycles per access.
  - Back-to-back accesses by the same port are legal: the requester keeps req high with new addr/write/wdata by the DONE cycle.
- Requester rules:
  - req, addr, write and wdata need only be valid at the granting edge; they are latched, so changes afterwards are ignored.
  - A requester may drop req before being granted (request withdrawn, no ack).
- Fairness: under continuous requests from both ports, grants strictly alternate A, B, A, B. Neither port waits more than one access period beyond its own.
- Write repetition: holding mem_write for MEM_LAT+1 edges repeats an identical byte write; this is idempotent and required. The companion byte in the same 16-bit word is never modified.
- mem_addr and mem_data_in retain their last values in IDLE (don't-care to the wrapper because mem_write=0).
- Reset mid-ACCESS or mid-DONE:
  - All registers return to reset values at that edge; no ack is issued.
  - A store in flight may or may not have reached the SPRAM; the requester must reissue it.
- ack is never asserted on both ports in the same cycle.
- ack is never asserted without a preceding grant.

Test Plan:
- Single load, A only: preload mem byte 0x0101=0x5A, a_req=1, a_write=0, a_addr=0x0101 at edge T → a_ack=1 only in the cycle after T+4; a_rdata=0x5A; b_ack stays 0; no further ack while a_req=0.
- Store then load, B then A: B stores 0x3C to 0x0200 and 0xC3 to 0x0201 → A loads 0x0200 → 0x3C, and loads 0x0201 → 0xC3 (odd/even byte lanes independent).
- Simultaneous requests from reset: a_req=b_req=1 at the same edge → A granted first; B's ack is 6 cycles after A's ack; the next tie is granted to A again only after B has been served.
- Starvation: A requests continuously, B raises req once → B's ack arrives within 12 cycles; the overall ack sequence is A, B, A, …
- Reset in ACCESS: a B store of 0x77 to 0x0010 is in flight; rst=1 for one edge at T+2 → no ack; mem_write=0 the cycle after that edge; the next tie is granted to A.
- Withdrawn request: b_req pulses for one cycle while A is in ACCESS → B is never granted; no b_ack.

Source files
------------

// File: rtl/spram_arbiter.sv
// Round-robin req/ack arbiter sharing one byte-wide SPRAM wrapper between two requesters.
// Hides the wrapper's fixed MEM_LAT pipeline behind a one-cycle ack pulse per access.
module spram_arbiter #(
  parameter int MEM_LAT = 3,
  parameter int ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_grant_q;  // 1 = port B was granted last
  logic                owner_q;       // 1 = port B owns the current access
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_write_q;
  logic [7:0]          mem_wdata_q;
  logic                a_ack_q, b_ack_q;
  logic [7:0]          a_rdata_q, b_rdata_q;

  logic grant_a_d, grant_b_d;

  always_comb begin
    grant_a_d = a_req && (!b_req || last_grant_q);
    grant_b_d = b_req && !grant_a_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_write_q <= 1'b0;
          if (grant_a_d || grant_b_d) begin
            owner_q      <= grant_b_d;
            last_grant_q <= grant_b_d;
            mem_addr_q   <= grant_b_d ? b_addr  : a_addr;
            mem_write_q  <= grant_b_d ? b_write : a_write;
            mem_wdata_q  <= grant_b_d ? b_wdata : a_wdata;
            cnt_q        <= '0;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Stores keep mem_write high for the whole window; repeating the byte write is harmless.
          if (cnt_q == LAT_C) begin
            if (!mem_write_q) begin
              if (owner_q) b_rdata_q <= mem_data_out;
              else         a_rdata_q <= mem_data_out;
            end
            if (owner_q) b_ack_q <= 1'b1;
            else         a_ack_q <= 1'b1;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_write   = mem_write_q;
  assign mem_data_in = mem_wdata_q;

endmodule
